// File: rtl/serial_chunk_adder_if.sv
// Operand/result handshake bundle for serial_chunk_adder.
// The producer/consumer side uses the master modport; the adder uses slave.
interface serial_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract: WIDTH-bit A+B+cin or A-B, CHUNK bits per clock,
// with a registered carry linking consecutive chunks.
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                clk,
  input logic                rst,
  serial_chunk_adder_if.slave bus
);
  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCH        = WIDTH / CHUNK_SAFE;
  localparam int IDX_W      = (NCH > 1) ? $clog2(NCH) : 1;
  // Chunk table is padded to a power of two so idx never indexes past its end.
  localparam int NSLOT      = 1 << IDX_W;

  if (CHUNK < 1 || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_params
    $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               carry_reg, carry_next;
  logic [WIDTH-1:0]   a_op_reg, a_op_next;
  logic [WIDTH-1:0]   b_op_reg, b_op_next;
  logic [WIDTH-1:0]   sum_reg, sum_next;
  logic               cout_reg, cout_next;
  logic               ovf_reg, ovf_next;

  logic [CHUNK_SAFE-1:0] a_chunk [NSLOT];
  logic [CHUNK_SAFE-1:0] b_chunk [NSLOT];
  logic [CHUNK_SAFE:0]   chunk_res;
  logic                  last_chunk;

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slice
      if (gi < NCH) begin : g_real
        assign a_chunk[gi] = a_op_reg[gi*CHUNK_SAFE +: CHUNK_SAFE];
        assign b_chunk[gi] = b_op_reg[gi*CHUNK_SAFE +: CHUNK_SAFE];
      end else begin : g_pad
        assign a_chunk[gi] = '0;
        assign b_chunk[gi] = '0;
      end
    end
  endgenerate

  assign chunk_res  = {1'b0, a_chunk[idx_reg]} + {1'b0, b_chunk[idx_reg]}
                    + {{CHUNK_SAFE{1'b0}}, carry_reg};
  assign last_chunk = (idx_reg == IDX_W'(NCH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_op_reg  <= '0;
      b_op_reg  <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      carry_reg <= carry_next;
      a_op_reg  <= a_op_next;
      b_op_reg  <= b_op_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    carry_next = carry_reg;
    a_op_next  = a_op_reg;
    b_op_next  = b_op_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is folded into the add as A + ~B + 1.
          a_op_next  = bus.in_a;
          b_op_next  = bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_next = bus.in_sub ? 1'b1 : bus.in_cin;
          sum_next   = '0;
          idx_next   = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < NCH; i++) begin
          if (idx_reg == IDX_W'(i)) begin
            sum_next[i*CHUNK_SAFE +: CHUNK_SAFE] = chunk_res[CHUNK_SAFE-1:0];
          end
        end
        carry_next = chunk_res[CHUNK_SAFE];
        if (last_chunk) begin
          cout_next  = chunk_res[CHUNK_SAFE];
          ovf_next   = (a_op_reg[WIDTH-1] == b_op_reg[WIDTH-1]) &&
                       (chunk_res[CHUNK_SAFE-1] != a_op_reg[WIDTH-1]);
          idx_next   = '0;
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_sum   = sum_reg;
  assign bus.out_cout  = cout_reg;
  assign bus.out_ovf   = ovf_reg;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench for serial_chunk_adder: directed arithmetic cases, backpressure,
// mid-operation reset and a randomized regression against a full-width arithmetic model.
module tb_serial_chunk_adder #(
  parameter int CHUNK = 4
);
  localparam int W   = 16;
  localparam int NCH = W / CHUNK;
  localparam int MAX_WAIT = 64;

  logic clk;
  logic rst;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  serial_chunk_adder_if #(.WIDTH(W)) bus ();

  serial_chunk_adder #(.WIDTH(W), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full-width reference: {cout, ovf, sum} from plain arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      s    = full[W-1:0];
      co   = full[W];
      ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      s    = a - b;
      co   = (a >= b);
      ov   = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end
    return {co, ov, s};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input bit noise, output int lat,
                        output logic [W-1:0] s, output logic co, output logic ov);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = cin;
    bus.in_sub    = sub;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    // Scramble operands after acceptance; the result must not change.
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_cin   = 1'($urandom);
    bus.in_sub   = 1'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
      if (noise) bus.out_ready = 1'($urandom);
    end
    s  = bus.out_sum;
    co = bus.out_cout;
    ov = bus.out_ovf;
  endtask

  task automatic finish_op();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.out_cout, bus.out_ovf, bus.out_sum} !== {2'b00, {W{1'b0}}})
      $display("FAIL reset_result got cout=%b ovf=%b sum=%h want 0/0/0000",
               bus.out_cout, bus.out_ovf, bus.out_sum);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    $display("reset: out_valid=%b in_ready=%b sum=%h", bus.out_valid, bus.in_ready, bus.out_sum);
  endtask

  task automatic test_arith();
    logic [W-1:0] ta   [5] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005, 16'h8000};
    logic [W-1:0] tb   [5] = '{16'h0001, 16'h0001, 16'h4321, 16'h0007, 16'h0001};
    logic         tcin [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic         tsub [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] esum [5] = '{16'h0000, 16'h8000, 16'h5556, 16'hFFFE, 16'h7FFF};
    logic         eco  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         eov  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int lat;
    logic [W-1:0] s;
    logic co, ov;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tcin[i], tsub[i], 1'b0, lat, s, co, ov);
      $display("arith %0d: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
               i, ta[i], tb[i], tcin[i], tsub[i], s, co, ov, lat);
      chk_cnt++;
      if (lat !== NCH) $display("FAIL arith%0d_latency got %0d want %0d", i, lat, NCH);
      else pass_cnt++;
      chk_cnt++;
      if (s !== esum[i]) $display("FAIL arith%0d_sum got %h want %h", i, s, esum[i]);
      else pass_cnt++;
      chk_cnt++;
      if (co !== eco[i]) $display("FAIL arith%0d_cout got %b want %b", i, co, eco[i]);
      else pass_cnt++;
      chk_cnt++;
      if (ov !== eov[i]) $display("FAIL arith%0d_ovf got %b want %b", i, ov, eov[i]);
      else pass_cnt++;
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] s;
    logic co, ov;
    logic [W+1:0] exp_r;
    exp_r = ref_op(16'hA5A5, 16'h1111, 1'b1, 1'b0);
    run_op(16'hA5A5, 16'h1111, 1'b1, 1'b0, 1'b0, lat, s, co, ov);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = W'($urandom);
      bus.in_b     = W'($urandom);
      @(posedge clk);
      #1;
      chk_cnt++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold%0d got valid=%b ready=%b want 1/0", c, bus.out_valid, bus.in_ready);
      else pass_cnt++;
      chk_cnt++;
      if ({bus.out_cout, bus.out_ovf, bus.out_sum} !== exp_r)
        $display("FAIL bp_result%0d got %h want %h", c,
                 {bus.out_cout, bus.out_ovf, bus.out_sum}, exp_r);
      else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    finish_op();
    $display("backpressure: released, out_valid=%b in_ready=%b sum=%h",
             bus.out_valid, bus.in_ready, bus.out_sum);
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL bp_release got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    else pass_cnt++;
    chk_cnt++;
    if (bus.out_sum !== exp_r[W-1:0])
      $display("FAIL bp_sum_kept got %h want %h", bus.out_sum, exp_r[W-1:0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [W-1:0] s;
    logic co, ov;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'hFFFF;
    bus.in_b     = 16'hFFFF;
    bus.in_cin   = 1'b1;
    bus.in_sub   = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL midrst_state got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, s, co, ov);
    $display("reset_mid: 00ff+0001 -> sum=%h cout=%b lat=%0d", s, co, lat);
    chk_cnt++;
    if (lat !== NCH) $display("FAIL midrst_latency got %0d want %0d", lat, NCH);
    else pass_cnt++;
    chk_cnt++;
    if ({co, s} !== {1'b0, 16'h0100}) $display("FAIL midrst_result got %b/%h want 0/0100", co, s);
    else pass_cnt++;
    finish_op();
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] a, b, s;
    logic cin, sub, co, ov;
    logic [W+1:0] exp_r;
    for (int n = 0; n < 1000; n++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      if (n % 8 == 0) b = ~a;
      exp_r = ref_op(a, b, cin, sub);
      run_op(a, b, cin, sub, 1'b1, lat, s, co, ov);
      $display("rand %0d: a=%h b=%h cin=%b sub=%b -> %b/%b/%h lat=%0d",
               n, a, b, cin, sub, co, ov, s, lat);
      chk_cnt++;
      if (lat !== NCH) $display("FAIL rand%0d_latency got %0d want %0d", n, lat, NCH);
      else pass_cnt++;
      chk_cnt++;
      if ({co, ov, s} !== exp_r)
        $display("FAIL rand%0d_result got %b/%b/%h want %b/%b/%h", n, co, ov, s,
                 exp_r[W+1], exp_r[W], exp_r[W-1:0]);
      else pass_cnt++;
      finish_op();
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
